switch_event_repeat: RTL and testbench

- Downstream stage of the pong switch debouncer. Consumes one debounced switch level and produces clean single-cycle events: press, release, and auto-repeat while held.
- Feeds the paddle/menu logic in the 25 MHz pixel-clock domain.
- One instance per debounced button.

---
 rtl/switch_event_repeat.sv | 88 ++++++++
 tb/tb_switch_event_repeat.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/switch_event_repeat.sv
// switch_event_repeat: turns a debounced switch level into press, release and auto-repeat pulses
module switch_event_repeat #(
  parameter int HOLD_DELAY    = 12500000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter int CNT_WIDTH     = 24
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_switch,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_event,
  output logic o_held
);
  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REPEAT_PERIOD - 1);
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic prev, rise, fall, press_nx, release_nx, repeat_nx;
  assign rise = i_switch & ~prev;
  assign fall = ~i_switch & prev;
  // next state, counter and pulse decisions; release beats a coincident terminal count
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    repeat_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (rise) begin
          press_nx = 1'b1;
          state_nx = PRESSED;
        end
      end
      PRESSED: begin
        if (fall) begin
          release_nx = 1'b1;
          state_nx   = IDLE;
          cnt_nx     = '0;
        end else if (i_switch) begin
          repeat_nx = cnt == HOLD_LAST;
          state_nx  = repeat_nx ? REPEAT : PRESSED;
          cnt_nx    = repeat_nx ? '0 : cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (fall) begin
          release_nx = 1'b1;
          state_nx   = IDLE;
          cnt_nx     = '0;
        end else begin
          repeat_nx = i_switch && cnt == REP_LAST;
          cnt_nx    = repeat_nx ? '0 : cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end
  // state, counter, edge history and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      prev      <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_repeat  <= 1'b0;
      o_event   <= 1'b0;
      o_held    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      prev      <= i_switch;
      o_press   <= press_nx;
      o_release <= release_nx;
      o_repeat  <= repeat_nx;
      o_event   <= press_nx | repeat_nx;
      o_held    <= state_nx == REPEAT;
    end
  end
endmodule

// File: tb/tb_switch_event_repeat.sv
// tb_switch_event_repeat: directed checks of press, release, repeat and reset behaviour
module tb_switch_event_repeat;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_switch = 1'b0;
  logic o_press, o_release, o_repeat, o_event, o_held;
  logic [4:0] obs;
  int n_checks = 0;
  int n_fail = 0;
  assign obs = {o_press, o_release, o_repeat, o_event, o_held};
  switch_event_repeat #(.HOLD_DELAY(8), .REPEAT_PERIOD(4), .CNT_WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_switch(i_switch),
    .o_press(o_press), .o_release(o_release), .o_repeat(o_repeat),
    .o_event(o_event), .o_held(o_held)
  );
  always #5 i_clk = ~i_clk;
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic test_reset();
    i_rst_n = 1'b0;
    i_switch = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (obs !== 5'b00000) begin n_fail++; $display("FAIL reset k=%0d got %b exp 00000", k, obs); end
    end
    i_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (obs !== 5'b00000) begin n_fail++; $display("FAIL idle_low k=%0d got %b exp 00000", k, obs); end
    end
  endtask
  task automatic test_hold();
    logic [4:0] exp;
    logic rep;
    i_switch = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      rep = (k >= 8) && ((k - 8) % 4 == 0);
      exp = {k == 0, 1'b0, rep, rep || k == 0, k >= 8};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL hold k=%0d got %b exp %b", k, obs, exp); end
    end
    i_switch = 1'b0;
    tick();
    n_checks++;
    if (obs !== 5'b01000) begin n_fail++; $display("FAIL hold_release got %b exp 01000", obs); end
    tick();
    n_checks++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL hold_after got %b exp 00000", obs); end
  endtask
  task automatic test_short();
    logic [4:0] exp;
    i_switch = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp = (k == 0) ? 5'b10010 : 5'b00000;
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL short k=%0d got %b exp %b", k, obs, exp); end
    end
    i_switch = 1'b0;
    tick();
    n_checks++;
    if (obs !== 5'b01000) begin n_fail++; $display("FAIL short_release got %b exp 01000", obs); end
    tick();
  endtask
  task automatic test_terminal();
    logic [4:0] exp;
    i_switch = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp = (k == 0) ? 5'b10010 : 5'b00000;
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL term k=%0d got %b exp %b", k, obs, exp); end
    end
    i_switch = 1'b0;
    tick();
    n_checks++;
    if (obs !== 5'b01000) begin n_fail++; $display("FAIL term_release got %b exp 01000", obs); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (obs !== 5'b00000) begin n_fail++; $display("FAIL term_idle k=%0d got %b exp 00000", k, obs); end
    end
  endtask
  task automatic test_reset_mid();
    logic [4:0] exp;
    logic rep;
    i_switch = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      rep = k == 8;
      exp = {k == 0, 1'b0, rep, rep || k == 0, k >= 8};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL pre_rst k=%0d got %b exp %b", k, obs, exp); end
    end
    i_rst_n = 1'b0;
    tick();
    n_checks++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL mid_rst got %b exp 00000", obs); end
    i_rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      rep = k == 8;
      exp = {k == 0, 1'b0, rep, rep || k == 0, k >= 8};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL post_rst k=%0d got %b exp %b", k, obs, exp); end
    end
    i_switch = 1'b0;
    tick();
    n_checks++;
    if (obs !== 5'b01000) begin n_fail++; $display("FAIL post_rst_release got %b exp 01000", obs); end
    tick();
  endtask
  task automatic test_glitch();
    logic [4:0] exp;
    logic rep;
    i_switch = 1'b1;
    tick();
    n_checks++;
    if (obs !== 5'b10010) begin n_fail++; $display("FAIL glitch_press got %b exp 10010", obs); end
    i_switch = 1'b0;
    tick();
    n_checks++;
    if (obs !== 5'b01000) begin n_fail++; $display("FAIL glitch_release got %b exp 01000", obs); end
    tick();
    n_checks++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL glitch_gap got %b exp 00000", obs); end
    i_switch = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick();
      rep = k == 8 || k == 12;
      exp = {k == 0, 1'b0, rep, rep || k == 0, k >= 8};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL glitch_hold k=%0d got %b exp %b", k, obs, exp); end
    end
    i_switch = 1'b0;
    tick();
    n_checks++;
    if (obs !== 5'b01000) begin n_fail++; $display("FAIL glitch_end got %b exp 01000", obs); end
    tick();
  endtask
  initial begin
    test_reset();
    test_hold();
    test_short();
    test_terminal();
    test_reset_mid();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
